// File: rtl/alu_seq_pkg.sv
// Shared funct/op codes, FSM state type and legality check for alu_op_sequencer.
package alu_seq_pkg;

    localparam logic [2:0] FUNCT_AND = 3'b000;
    localparam logic [2:0] FUNCT_OR  = 3'b001;
    localparam logic [2:0] FUNCT_ADD = 3'b010;
    localparam logic [2:0] FUNCT_SUB = 3'b110;
    localparam logic [2:0] FUNCT_SLT = 3'b111;

    localparam logic [2:0] ALU_OP_SUB = FUNCT_SUB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic funct_legal(input logic [2:0] f);
        return (f == FUNCT_AND) || (f == FUNCT_OR) ||
               (f == FUNCT_ADD) || (f == FUNCT_SUB) ||
               (f == FUNCT_SLT);
    endfunction

endpackage

// File: rtl/alu_slt_fix.sv
// Signed less-than recovered from a subtraction result: sign of a-b
// corrected by the two's-complement overflow flag.
module alu_slt_fix #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] z_i,
    output logic [WIDTH-1:0] res_o
);

    logic ovf;

    always_comb begin
        ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
              (z_i[WIDTH-1] != a_i[WIDTH-1]);
        res_o = '0;
        res_o[0] = z_i[WIDTH-1] ^ ovf;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Request -> external ALU -> response sequencer (IDLE/EXEC/RESP).
// ALU_SLT_EMUL_EN: run SLT on the SUB datapath and fix up the result.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [15:0]      done_cnt
);

`ifdef ALU_SLT_EMUL_EN
    localparam bit SltEmul = 1'b1;
`else
    localparam bit SltEmul = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [2:0]       funct_q, funct_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] slt_res;
    logic             slt_emul;

    alu_slt_fix #(
        .WIDTH (WIDTH)
    ) u_slt_fix (
        .a_i   (a_q),
        .b_i   (b_q),
        .z_i   (alu_z),
        .res_o (slt_res)
    );

    assign slt_emul  = SltEmul && (funct_q == FUNCT_SLT);
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign done_cnt  = cnt_q;

    always_comb begin
        state_d   = state_q;
        funct_d   = funct_q;
        a_d       = a_q;
        b_d       = b_q;
        data_d    = data_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_op    = 3'b000;
        alu_a     = '0;
        alu_b     = '0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    funct_d = req_funct;
                    a_d     = req_a;
                    b_d     = req_b;
                    if (funct_legal(req_funct)) begin
                        state_d = EXEC;
                    end else begin
                        // Illegal ops skip the ALU entirely
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            EXEC: begin
                alu_op  = slt_emul ? ALU_OP_SUB : funct_q;
                alu_a   = a_q;
                alu_b   = b_q;
                data_d  = slt_emul ? slt_res : alu_z;
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            funct_q <= 3'b000;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            funct_q <= funct_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU plus transaction model,
// per-cycle compare and directed vectors with literal expectations.
module tb_alu_op_sequencer;

`ifdef ALU_SLT_EMUL_EN
    localparam bit EMUL = 1'b1;
`else
    localparam bit EMUL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct;
    logic [7:0]  req_a, req_b;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a, alu_b, alu_z;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic [15:0] done_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_funct (req_funct),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_z     (alu_z),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .done_cnt  (done_cnt)
    );

    // External combinational ALU
    always_comb begin
        alu_z = 8'h00;
        case (alu_op)
            3'b000: alu_z = alu_a & alu_b;
            3'b001: alu_z = alu_a | alu_b;
            3'b010: alu_z = alu_a + alu_b;
            3'b110: alu_z = alu_a - alu_b;
            3'b111: alu_z = {7'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_z = 8'h00;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [2:0] f);
        return f == 3'b000 || f == 3'b001 || f == 3'b010 ||
               f == 3'b110 || f == 3'b111;
    endfunction

    function automatic logic [7:0] gold(input logic [2:0] f,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
        case (f)
            3'b000: return a & b;
            3'b001: return a | b;
            3'b010: return a + b;
            3'b110: return a - b;
            3'b111: return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [2:0] exp_op(input logic [2:0] f);
        return (f == 3'b111 && EMUL) ? 3'b110 : f;
    endfunction

    // Transaction model: busy flag plus cycles elapsed since accept
    bit          m_busy = 1'b0;
    int          m_since = 0;
    logic [2:0]  m_f = 3'b000;
    logic [7:0]  m_a = 8'h00, m_b = 8'h00;
    logic [15:0] m_cnt = 16'd0;

    function automatic bit m_valid();
        return m_busy && (m_since >= (legal(m_f) ? 1 : 0));
    endfunction

    function automatic bit m_exec();
        return m_busy && legal(m_f) && m_since == 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_since = 0;
            m_cnt = 16'd0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy = 1'b1;
                m_since = 0;
                m_f = req_funct;
                m_a = req_a;
                m_b = req_b;
            end
        end else if (m_valid() && rsp_ready) begin
            m_busy = 1'b0;
            m_cnt = m_cnt + 16'd1;
        end else begin
            m_since++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("req_ready", 32'(req_ready), 32'(!m_busy));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid()));
            chk("alu_op", 32'(alu_op), m_exec() ? 32'(exp_op(m_f)) : 32'd0);
            chk("alu_a", 32'(alu_a), m_exec() ? 32'(m_a) : 32'd0);
            chk("alu_b", 32'(alu_b), m_exec() ? 32'(m_b) : 32'd0);
            chk("done_cnt", 32'(done_cnt), 32'(m_cnt));
            if (m_valid()) begin
                chk("rsp_data", 32'(rsp_data),
                    legal(m_f) ? 32'(gold(m_f, m_a, m_b)) : 32'd0);
                chk("rsp_err", 32'(rsp_err), 32'(!legal(m_f)));
            end
        end
    end

    task automatic send(input logic [2:0] f, input logic [7:0] a,
                        input logic [7:0] b, input int hold,
                        output int lat, output logic [2:0] op_x,
                        output logic [7:0] z_x, output logic [7:0] d,
                        output logic e);
        lat = 0;
        op_x = 3'b000;
        z_x = 8'h00;
        d = 8'h00;
        e = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_funct = f;
        req_a = a;
        req_b = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = n;
                d = rsp_data;
                e = rsp_err;
                break;
            end
            if (n == 1) begin
                op_x = alu_op;
                z_x = alu_z;
            end
        end
        if (lat == 0) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_data", 32'(rsp_data), 32'(d));
            chk("stall_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [2:0] f;
        logic [7:0] a;
        logic [7:0] b;
        int         hold;
        logic [7:0] ed;
        logic       ee;
        int         elat;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV] = '{
        '{3'b010, 8'h05, 8'h03, 0, 8'h08, 1'b0, 2},
        '{3'b110, 8'h03, 8'h05, 0, 8'hFE, 1'b0, 2},
        '{3'b111, 8'h80, 8'h01, 0, 8'h01, 1'b0, 2},
        '{3'b011, 8'h55, 8'hAA, 0, 8'h00, 1'b1, 1},
        '{3'b000, 8'hF0, 8'h3C, 0, 8'h30, 1'b0, 2},
        '{3'b001, 8'hF0, 8'h0C, 0, 8'hFC, 1'b0, 2},
        '{3'b111, 8'h01, 8'h80, 0, 8'h00, 1'b0, 2},
        '{3'b111, 8'h7F, 8'h80, 0, 8'h00, 1'b0, 2},
        '{3'b010, 8'hFF, 8'h02, 0, 8'h01, 1'b0, 2},
        '{3'b110, 8'h00, 8'h01, 0, 8'hFF, 1'b0, 2},
        '{3'b100, 8'h12, 8'h34, 0, 8'h00, 1'b1, 1},
        '{3'b101, 8'h77, 8'h11, 0, 8'h00, 1'b1, 1},
        '{3'b010, 8'h10, 8'h20, 5, 8'h30, 1'b0, 2}
    };

    initial begin
        int         lat;
        logic [2:0] op_x;
        logic [7:0] z_x, d;
        logic       e;

        rst_n = 1'b0;
        req_valid = 1'b0;
        req_funct = 3'b000;
        req_a = 8'h00;
        req_b = 8'h00;
        rsp_ready = 1'b0;
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_done_cnt", 32'(done_cnt), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            send(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].hold,
                 lat, op_x, z_x, d, e);
            chk("latency", 32'(lat), 32'(vecs[i].elat));
            chk("vec_data", 32'(d), 32'(vecs[i].ed));
            chk("vec_err", 32'(e), 32'(vecs[i].ee));
            chk("vec_done_cnt", 32'(done_cnt), 32'(i + 1));
            if (vecs[i].elat == 2) begin
                chk("exec_op", 32'(op_x),
                    (vecs[i].f == 3'b111 && EMUL) ? 32'd6 : 32'(vecs[i].f));
            end
            if (vecs[i].f == 3'b111 && vecs[i].a == 8'h80) begin
                chk("slt_alu_z", 32'(z_x), EMUL ? 32'h7F : 32'h01);
            end
        end

        // Reset while a response is pending
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_funct = 3'b010;
        req_a = 8'h01;
        req_b = 8'h02;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_done_cnt", 32'(done_cnt), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_data", 32'(rsp_data), 32'd0);
        chk("mid_rst_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        send(3'b110, 8'h09, 8'h04, 0, lat, op_x, z_x, d, e);
        chk("post_rst_lat", 32'(lat), 32'd2);
        chk("post_rst_data", 32'(d), 32'h05);
        chk("post_rst_done_cnt", 32'(done_cnt), 32'd1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
